instr_fetch_resp: RTL and testbench

//  Responder side of the PC fetch interface. It accepts word-aligned byte addresses from the

---
 rtl/instr_fetch_resp_if.sv | 38 +++
 rtl/instr_fetch_resp.sv | 107 ++++++++++
 tb/tb_instr_fetch_resp.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_resp_if.sv
// Fetch request/response bus between the PC, the fetch responder and decode.
// Request and response transfers each happen on a rising edge where valid && ready; ld_* is an unconditional write.
interface instr_fetch_resp_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [31:0]       rsp_instr;
  logic              rsp_err;
  logic [31:0]       rsp_imm;
  logic [25:0]       rsp_jtarget;
  logic              rsp_is_br;
  logic              rsp_is_jmp;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_addr;
  logic [31:0]       ld_data;
  logic [1:0]        dbg_state;

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, rsp_imm,
           rsp_jtarget, rsp_is_br, rsp_is_jmp, dbg_state
  );

  modport master (
    output req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, rsp_imm,
           rsp_jtarget, rsp_is_br, rsp_is_jmp, dbg_state
  );
endinterface

// File: rtl/instr_fetch_resp.sv
// Instruction fetch responder: synchronous instruction memory read, one in-flight stage and a
// 2-entry response FIFO with decoded immediate/jump/branch fields at its head.
module instr_fetch_resp #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_resp_if.slave     bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WI    = ADDR_W - 2;
  localparam logic [31:0] DEPTH_U = DEPTH;

  // FIFO occupancy doubles as the state exposed on dbg_state.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
    logic              err;
  } ent_t;

  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inf_addr_q, inf_addr_d;
  logic              inf_err_q, inf_err_d;
  ent_t              head_q, head_d;
  ent_t              tail_q, tail_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_rdata;

  logic [WI-1:0]     word_idx;
  logic              req_err;
  logic              accept;
  logic              deq;
  ent_t              new_ent;

  assign word_idx = bus.req_addr[ADDR_W-1:2];
  assign req_err  = (bus.req_addr[1:0] != 2'b00) ||
                    ({{(32-WI){1'b0}}, word_idx} >= DEPTH_U);
  // In-flight read counts as a slot so an enqueue can never find the FIFO full.
  assign bus.req_ready = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
  assign accept        = bus.req_valid && bus.req_ready;
  assign deq           = (count_q != ST_EMPTY) && bus.rsp_ready;

  // Memory survives rst; a same-cycle load and fetch of one index returns the old word.
  always_ff @(posedge clk) begin
    if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
    if (accept && !req_err) mem_rdata <= mem[word_idx[IDX_W-1:0]];
  end

  always_comb begin
    new_ent    = '{addr: inf_addr_q, instr: (inf_err_q ? 32'h0 : mem_rdata), err: inf_err_q};
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = accept;
    inf_addr_d = accept ? bus.req_addr : inf_addr_q;
    inf_err_d  = accept ? req_err : inf_err_q;
    if (bus.flush) begin
      // A request accepted alongside flush is the redirect target and survives in flight.
      count_d = ST_EMPTY;
    end else begin
      if (deq) begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      if (inflight_q) begin
        if (count_d == ST_EMPTY) head_d = new_ent;
        else                     tail_d = new_ent;
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= ST_EMPTY;
      inflight_q <= 1'b0;
      inf_addr_q <= '0;
      inf_err_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      inf_addr_q <= inf_addr_d;
      inf_err_q  <= inf_err_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.rsp_valid   = (count_q == ST_ONE) || (count_q == ST_TWO);
  assign bus.rsp_addr    = head_q.addr;
  assign bus.rsp_instr   = head_q.instr;
  assign bus.rsp_err     = head_q.err;
  assign bus.rsp_imm     = {{16{head_q.instr[15]}}, head_q.instr[15:0]};
  assign bus.rsp_jtarget = head_q.instr[25:0];
  assign bus.rsp_is_br   = (head_q.instr[31:26] == 6'h04) || (head_q.instr[31:26] == 6'h05);
  assign bus.rsp_is_jmp  = (head_q.instr[31:26] == 6'h02) || (head_q.instr[31:26] == 6'h03);
  assign bus.dbg_state   = count_q;
endmodule

// File: tb/tb_instr_fetch_resp.sv
// Bench for instr_fetch_resp: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_resp;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 128;
  localparam int IDX_W  = 7;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
    logic              err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_resp_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();
  instr_fetch_resp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  bit chk_en = 1'b0;

  // Model: responses waiting at the consumer, the one read in flight, and the memory image.
  rsp_t              exp_q[$];
  bit                inf_v;
  rsp_t              inf_e;
  logic [31:0]       mem_m [DEPTH];
  logic [ADDR_W-1:0] dut_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t make_rsp(input logic [ADDR_W-1:0] a);
    rsp_t r;
    int idx;
    idx     = int'(a) / 4;
    r.addr  = a;
    r.err   = (int'(a) % 4 != 0) || (idx >= DEPTH);
    r.instr = 32'h0;
    if (!r.err) r.instr = mem_m[idx];
    return r;
  endfunction

  function automatic bit model_ready();
    return (exp_q.size() + int'(inf_v)) < 2;
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    return {{16{i[15]}}, i[15:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    inf_v = 1'b0;
  endtask

  task automatic model_step();
    rsp_t nr;
    bit acc, deq;
    if (rst) begin
      model_reset();
      return;
    end
    acc = bus.req_valid && model_ready();
    deq = (exp_q.size() > 0) && bus.rsp_ready;
    nr  = make_rsp(bus.req_addr);
    if (deq) void'(exp_q.pop_front());
    if (bus.flush) exp_q.delete();
    else if (inf_v) exp_q.push_back(inf_e);
    inf_v = acc;
    inf_e = nr;
    if (bus.ld_en) mem_m[bus.ld_addr] = bus.ld_data;
  endtask

  // Driver: record handshakes seen before the edge, advance one clock, update the model.
  task automatic tick();
    if (bus.rsp_valid && bus.rsp_ready) dut_log.push_back(bus.rsp_addr);
    if (bus.req_valid && bus.req_ready) acc_cnt++;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    check("issue_accepted", {31'b0, ok}, 32'd1);
  endtask

  // Scoreboard compare: every cycle out of reset, DUT outputs against the model.
  rsp_t h;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("req_ready", {31'b0, bus.req_ready}, {31'b0, model_ready()});
      check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_q.size() > 0});
      check("occupancy", {30'b0, bus.dbg_state}, exp_q.size());
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        check("rsp_addr",    {22'b0, bus.rsp_addr}, {22'b0, h.addr});
        check("rsp_instr",   bus.rsp_instr, h.instr);
        check("rsp_err",     {31'b0, bus.rsp_err}, {31'b0, h.err});
        check("rsp_imm",     bus.rsp_imm, exp_imm(h.instr));
        check("rsp_jtarget", {6'b0, bus.rsp_jtarget}, {6'b0, h.instr[25:0]});
        check("rsp_is_br",   {31'b0, bus.rsp_is_br},
              {31'b0, (h.instr[31:26] == 6'h04) || (h.instr[31:26] == 6'h05)});
        check("rsp_is_jmp",  {31'b0, bus.rsp_is_jmp},
              {31'b0, (h.instr[31:26] == 6'h02) || (h.instr[31:26] == 6'h03)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    model_reset();
    #12;
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset_rsp_addr",  {22'b0, bus.rsp_addr}, 32'd0);
    check("reset_rsp_instr", bus.rsp_instr, 32'd0);
    check("reset_rsp_imm",   bus.rsp_imm, 32'd0);
    check("reset_jtarget",   {6'b0, bus.rsp_jtarget}, 32'd0);
    check("reset_flags",     {29'b0, bus.rsp_err, bus.rsp_is_br, bus.rsp_is_jmp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Program load: word0 bne, word1 beq -2, word2 jal, rest random.
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = IDX_W'(i);
      if (i == 0)      bus.ld_data = 32'h14A0_7FFF;
      else if (i == 1) bus.ld_data = 32'h1000_FFFE;
      else if (i == 2) bus.ld_data = 32'h0C00_0040;
      else             bus.ld_data = $urandom();
      tick();
    end
    bus.ld_en = 1'b0;

    // Single fetch: 2-edge latency and decoded fields.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 10'h004;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t1_valid", {31'b0, bus.rsp_valid}, 32'd1);
    check("t1_instr", bus.rsp_instr, 32'h1000_FFFE);
    check("t1_imm",   bus.rsp_imm, 32'hFFFF_FFFE);
    check("t1_is_br", {31'b0, bus.rsp_is_br}, 32'd1);
    check("t1_err",   {31'b0, bus.rsp_err}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick(); tick();

    // Back-to-back requests return in order.
    dut_log.delete();
    issue(10'h000); issue(10'h004); issue(10'h008);
    repeat (6) tick();
    check("t2_count", dut_log.size(), 32'd3);
    if (dut_log.size() == 3) begin
      check("t2_addr0", {22'b0, dut_log[0]}, 32'h000);
      check("t2_addr1", {22'b0, dut_log[1]}, 32'h004);
      check("t2_addr2", {22'b0, dut_log[2]}, 32'h008);
    end

    // Stalled consumer: only two requests accepted, then drain in order.
    dut_log.delete();
    acc_cnt = 0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_addr = ADDR_W'(32'h010 + 4 * acc_cnt);
      tick();
    end
    check("t3_accepted", acc_cnt, 32'd2);
    check("t3_req_ready", {31'b0, bus.req_ready}, 32'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (5) tick();
    check("t3_count", dut_log.size(), 32'd2);
    if (dut_log.size() == 2) begin
      check("t3_addr0", {22'b0, dut_log[0]}, 32'h010);
      check("t3_addr1", {22'b0, dut_log[1]}, 32'h014);
    end

    // Error responses: misaligned and out of range.
    bus.rsp_ready = 1'b0;
    issue(10'h006); tick();
    check("t4_mis_err",   {31'b0, bus.rsp_err}, 32'd1);
    check("t4_mis_instr", bus.rsp_instr, 32'd0);
    check("t4_mis_imm",   bus.rsp_imm, 32'd0);
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    issue(10'h200); tick();
    check("t4_oor_err",   {31'b0, bus.rsp_err}, 32'd1);
    check("t4_oor_instr", bus.rsp_instr, 32'd0);
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    issue(10'h1FC); tick();
    check("t4_last_err",  {31'b0, bus.rsp_err}, 32'd0);
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;

    // Flush: full FIFO vanishes; flush with a redirect request keeps only the new one.
    issue(10'h030); issue(10'h034); tick();
    check("t5_full", {30'b0, bus.dbg_state}, 32'd2);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    check("t5_flushed", {31'b0, bus.rsp_valid}, 32'd0);
    issue(10'h038); tick();
    check("t5_one_addr", {22'b0, bus.rsp_addr}, 32'h038);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 10'h020;
    tick();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    check("t5_after_flush", {31'b0, bus.rsp_valid}, 32'd0);
    dut_log.delete();
    bus.rsp_ready = 1'b1;
    repeat (4) tick();
    check("t5_count", dut_log.size(), 32'd1);
    if (dut_log.size() == 1) check("t5_redirect_addr", {22'b0, dut_log[0]}, 32'h020);

    // Asynchronous reset with a response pending; memory survives.
    bus.rsp_ready = 1'b0;
    issue(10'h004); tick();
    check("t6_pending", {31'b0, bus.rsp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("t6_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("t6_rst_instr", bus.rsp_instr, 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    issue(10'h004); tick();
    check("t6_mem_kept", bus.rsp_instr, 32'h1000_FFFE);
    bus.rsp_ready = 1'b1; tick(); tick();

    // Random traffic against the model.
    repeat (500) begin
      bus.req_valid = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) bus.req_addr = ADDR_W'($urandom_range(0, 1023));
      else                           bus.req_addr = ADDR_W'(4 * $urandom_range(0, DEPTH - 1));
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      bus.flush     = $urandom_range(0, 19) == 0;
      bus.ld_en     = $urandom_range(0, 7) == 0;
      bus.ld_addr   = IDX_W'($urandom_range(0, DEPTH - 1));
      bus.ld_data   = $urandom();
      tick();
    end
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.ld_en = 1'b0; bus.rsp_ready = 1'b1;
    repeat (5) tick();
    check("drained", {31'b0, bus.rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
